// File: rtl/data_mem_store_unit_if.sv
// Store-request and data-memory word-port bundle for data_mem_store_unit.
// master: the store unit (drives the memory port); slave: MEM stage plus memory side.
interface data_mem_store_unit_if #(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_ADDR_WIDTH = 32
);
   logic                       st_valid;
   logic                       st_ready;
   logic [DATA_ADDR_WIDTH-1:0] st_addr;
   logic [1:0]                 st_size;
   logic [DATA_WIDTH-1:0]      st_wdata;
   logic                       st_done;
   logic                       st_err;
   logic                       busy;
   logic                       mem_req;
   logic                       mem_grant;
   logic [DATA_ADDR_WIDTH-1:0] mem_raddr;
   logic [DATA_WIDTH-1:0]      mem_rdata;
   logic [DATA_ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0]      mem_wdata;
   logic                       mem_write;

   modport master (
      input  st_valid, st_addr, st_size, st_wdata, mem_grant, mem_rdata,
      output st_ready, st_done, st_err, busy, mem_req,
             mem_raddr, mem_waddr, mem_wdata, mem_write
   );

   modport slave (
      output st_valid, st_addr, st_size, st_wdata, mem_grant, mem_rdata,
      input  st_ready, st_done, st_err, busy, mem_req,
             mem_raddr, mem_waddr, mem_wdata, mem_write
   );
endinterface

// File: rtl/data_mem_store_unit.sv
// Byte/half/word store engine: turns byte-addressed stores into word read-modify-writes.
// Build option MISALIGN_TRAP_EN: word-spanning stores are trapped (st_err) instead of split.
//
// state | meaning
// IDLE  | ready for a store; st_done/st_err pulse here
// RD0   | read first word w0, capture merge on grant
// WR0   | write merged w0 on grant
// RD1   | read second word w1 (spanning store only)
// WR1   | write merged w1 on grant
module data_mem_store_unit #(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_ADDR_WIDTH = 32,
   parameter int NUM_WORDS       = 128
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_rst,
   data_mem_store_unit_if.master bus
);
   localparam int              AW  = DATA_ADDR_WIDTH;
   localparam logic [AW-1:0]   ONE = AW'(1);
   localparam logic [AW-1:0]   NW  = AW'(NUM_WORDS);

`ifdef MISALIGN_TRAP_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_WR0  = 3'd2
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_WR0  = 3'd2,
      S_RD1  = 3'd3,
      S_WR1  = 3'd4
   } state_t;
`endif

   state_t                state_q, state_d;
   logic [1:0]            off_q, off_d;
   logic [2:0]            end_q, end_d;
   logic [AW-1:0]         w0_q, w0_d;
   logic [AW-1:0]         w1_q, w1_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] merge_q, merge_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [2:0]            n_in;
   logic [2:0]            end_in;
   logic [AW-1:0]         w0_in;
   logic                  rd_hi;
   logic                  wr_hi;
   logic [2:0]            pos_v;
   logic [1:0]            sel_v;
   logic [DATA_WIDTH-1:0] merge_rd;

   always_comb begin
      case (bus.st_size)
         2'd0:    n_in = 3'd1;
         2'd1:    n_in = 3'd2;
         2'd2:    n_in = 3'd4;
         default: n_in = 3'd0;
      endcase
   end

   assign end_in = {1'b0, bus.st_addr[1:0]} + n_in;
   assign w0_in  = {2'b00, bus.st_addr[AW-1:2]};

`ifdef MISALIGN_TRAP_EN
   logic span_in;
   assign span_in = (end_in > 3'd4);
   assign rd_hi   = 1'b0;
   assign wr_hi   = 1'b0;
`else
   assign rd_hi   = (state_q == S_RD1);
   assign wr_hi   = (state_q == S_WR1);
`endif

   // Byte position pos_v counts across both words (4..7 = second word);
   // lanes inside [off, off+n) take store byte pos_v-off.
   always_comb begin
      merge_rd = bus.mem_rdata;
      pos_v    = 3'd0;
      sel_v    = 2'd0;
      for (int i = 0; i < 4; i++) begin
         pos_v = 3'(i) + {rd_hi, 2'b00};
         sel_v = 2'(pos_v - {1'b0, off_q});
         if ((pos_v >= {1'b0, off_q}) && (pos_v < end_q)) begin
            merge_rd[8*i +: 8] = wdata_q[{sel_v, 3'b000} +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      end_d   = end_q;
      w0_d    = w0_q;
      w1_d    = w1_q;
      wdata_d = wdata_q;
      merge_d = merge_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.st_valid) begin
               off_d   = bus.st_addr[1:0];
               end_d   = end_in;
               w0_d    = w0_in;
               w1_d    = (w0_in + ONE) % NW;
               wdata_d = bus.st_wdata;
               if (bus.st_size == 2'd3) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
`ifdef MISALIGN_TRAP_EN
               else if (span_in) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
`endif
               else begin
                  state_d = S_RD0;
               end
            end
         end
         S_RD0: begin
            if (bus.mem_grant) begin
               merge_d = merge_rd;
               state_d = S_WR0;
            end
         end
         S_WR0: begin
            if (bus.mem_grant) begin
`ifdef MISALIGN_TRAP_EN
               state_d = S_IDLE;
               done_d  = 1'b1;
`else
               if (end_q > 3'd4) begin
                  state_d = S_RD1;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
`endif
            end
         end
`ifndef MISALIGN_TRAP_EN
         S_RD1: begin
            if (bus.mem_grant) begin
               merge_d = merge_rd;
               state_d = S_WR1;
            end
         end
         S_WR1: begin
            if (bus.mem_grant) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q <= S_IDLE;
         off_q   <= '0;
         end_q   <= '0;
         w0_q    <= '0;
         w1_q    <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         end_q   <= end_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         wdata_q <= wdata_d;
         merge_q <= merge_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.st_ready  = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.mem_req   = (state_q != S_IDLE);
   assign bus.st_done   = done_q;
   assign bus.st_err    = err_q;
   assign bus.mem_raddr = rd_hi ? w1_q : w0_q;
   assign bus.mem_waddr = wr_hi ? w1_q : w0_q;
   assign bus.mem_wdata = merge_q;
   // The memory commits at the edge, so the strobe follows this cycle's grant.
   assign bus.mem_write = bus.mem_grant && ((state_q == S_WR0) || wr_hi);
endmodule

// File: tb/tb_data_mem_store_unit.sv
// Self-checking bench for data_mem_store_unit: vector table, corner sequences, random stores.
module tb_data_mem_store_unit;
   localparam int NW = 128;

   logic cpu_clk = 1'b0;
   logic cpu_rst;
   bit   preload_req = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] mem     [NW];
   logic [31:0] ref_mem [NW];

   data_mem_store_unit_if #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32)) bus ();

   data_mem_store_unit #(
      .DATA_WIDTH(32), .DATA_ADDR_WIDTH(32), .NUM_WORDS(NW)
   ) dut (
      .cpu_clk(cpu_clk),
      .cpu_rst(cpu_rst),
      .bus    (bus)
   );

   always #5 cpu_clk = ~cpu_clk;

   assign bus.mem_rdata = mem[bus.mem_raddr[6:0]];

   always @(posedge cpu_clk) begin
      if (preload_req) begin
         for (int i = 0; i < NW; i++) mem[i] = 32'h0;
         mem[4] = 32'h44332211;
         mem[5] = 32'h88776655;
         mem[6] = 32'h00000000;
      end else if (bus.mem_write) begin
         mem[bus.mem_waddr[6:0]] = bus.mem_wdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_st_done"},   bus.st_done,   0);
      chk({tag, "_st_err"},    bus.st_err,    0);
      chk({tag, "_mem_write"}, bus.mem_write, 0);
      chk({tag, "_mem_req"},   bus.mem_req,   0);
      chk({tag, "_busy"},      bus.busy,      0);
      chk({tag, "_mem_raddr"}, bus.mem_raddr, 0);
      chk({tag, "_mem_waddr"}, bus.mem_waddr, 0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      chk({tag, "_st_ready"},  bus.st_ready,  1);
   endtask

   task automatic preload();
      @(negedge cpu_clk);
      preload_req = 1'b1;
      @(posedge cpu_clk);
      #1 preload_req = 1'b0;
      for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
      ref_mem[4] = 32'h44332211;
      ref_mem[5] = 32'h88776655;
   endtask

   function automatic int size_bytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
   endfunction

   // Reference: each store byte k lands at byte address addr+k, with the word index wrapping.
   task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
      int n, off, word, lane;
      n   = size_bytes(size);
      off = int'(addr[1:0]);
      if (size == 2'd3) return;
`ifdef MISALIGN_TRAP_EN
      if (off + n > 4) return;
`endif
      for (int k = 0; k < n; k++) begin
         word = (int'(addr >> 2) + (off + k) / 4) % NW;
         lane = (off + k) % 4;
         ref_mem[word][8*lane +: 8] = data[8*k +: 8];
      end
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                           input int stall, input bit rnd, output int lat);
      logic [31:0] wa[$];
      logic [31:0] w0, w1;
      int          n, off, nwr, exp_nwr, bad;
      bit          span, got, err_seen, exp_err;
      n       = size_bytes(size);
      off     = int'(addr[1:0]);
      span    = (size != 2'd3) && (off + n > 4);
      w0      = addr >> 2;
      w1      = (w0 + 1) % NW;
      exp_err = (size == 2'd3);
      exp_nwr = (size == 2'd3) ? 0 : span ? 2 : 1;
`ifdef MISALIGN_TRAP_EN
      if (span) begin
         exp_err = 1'b1;
         exp_nwr = 0;
      end
`endif
      chk("st_ready_idle", bus.st_ready, 1);
      bus.mem_grant = (stall > 0) ? 1'b0 : 1'b1;
      bus.st_valid  = 1'b1;
      bus.st_addr   = addr;
      bus.st_size   = size;
      bus.st_wdata  = data;
      @(posedge cpu_clk);
      #1;
      bus.st_valid = 1'b0;
      bus.st_addr  = $urandom;
      bus.st_size  = 2'($urandom);
      bus.st_wdata = $urandom;
      nwr = 0; got = 1'b0; err_seen = 1'b0; lat = -1;
      for (int c = 1; c <= 80 && !got; c++) begin
         @(negedge cpu_clk);
         if (c <= stall)  bus.mem_grant = 1'b0;
         else if (rnd)    bus.mem_grant = ($urandom_range(0, 3) != 0);
         else             bus.mem_grant = 1'b1;
         #1;
         if (c <= stall) begin
            chk("stall_raddr", bus.mem_raddr, w0);
            chk("stall_no_write", bus.mem_write, 0);
         end
         if (bus.mem_write) begin
            wa.push_back(bus.mem_waddr);
            nwr++;
         end
         if (bus.st_done) begin
            got      = 1'b1;
            lat      = c - 1;
            err_seen = bus.st_err;
         end
      end
      chk("done_seen", got, 1);
      chk("num_writes", nwr, exp_nwr);
      chk("st_err", err_seen, exp_err);
      for (int i = 0; i < wa.size() && i < 2; i++) chk("write_addr", wa[i], (i == 0) ? w0 : w1);
      ref_store(addr, size, data);
      bad = 0;
      for (int i = 0; i < NW; i++) begin
         if (mem[i] !== ref_mem[i]) begin
            bad++;
            if (bad == 1) $display("FAIL mem_image: word %0d actual=%h required=%h", i, mem[i], ref_mem[i]);
         end
      end
      checks++;
      if (bad != 0) errors++;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] data;
      int          stall;
      logic [31:0] e4, e5, e6;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int  lat, minlat, n, off;
      bit  seen;
      logic [31:0] a, d;
      logic [1:0]  s;

      vecs[0] = '{32'h10, 2'd2, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h88776655, 32'h0, 2};
      vecs[1] = '{32'h12, 2'd0, 32'h000000AB, 0, 32'h44AB2211, 32'h88776655, 32'h0, 2};
`ifdef MISALIGN_TRAP_EN
      vecs[2] = '{32'h13, 2'd2, 32'hAABBCCDD, 0, 32'h44332211, 32'h88776655, 32'h0, 0};
      vecs[3] = '{32'h17, 2'd1, 32'h00001234, 0, 32'h44332211, 32'h88776655, 32'h0, 0};
`else
      vecs[2] = '{32'h13, 2'd2, 32'hAABBCCDD, 0, 32'hDD332211, 32'h88AABBCC, 32'h0, 4};
      vecs[3] = '{32'h17, 2'd1, 32'h00001234, 0, 32'h44332211, 32'h34776655, 32'h12, 4};
`endif
      vecs[4] = '{32'h10, 2'd3, 32'hFFFFFFFF, 0, 32'h44332211, 32'h88776655, 32'h0, 0};
      vecs[5] = '{32'h16, 2'd1, 32'h0000BEEF, 0, 32'h44332211, 32'hBEEF6655, 32'h0, 2};
      vecs[6] = '{32'h11, 2'd1, 32'h00005A5A, 0, 32'h445A5A11, 32'h88776655, 32'h0, 2};
      vecs[7] = '{32'h10, 2'd2, 32'hDEADBEEF, 3, 32'hDEADBEEF, 32'h88776655, 32'h0, 5};

      cpu_rst       = 1'b1;
      bus.st_valid  = 1'b0;
      bus.st_addr   = 32'h0;
      bus.st_size   = 2'd0;
      bus.st_wdata  = 32'h0;
      bus.mem_grant = 1'b1;
      repeat (3) @(posedge cpu_clk);
      @(negedge cpu_clk);
      chk_reset_outputs("reset");
      cpu_rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         preload();
         do_store(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].stall, 1'b0, lat);
         chk("latency", lat, vecs[i].lat);
         chk("mem4", mem[4], vecs[i].e4);
         chk("mem5", mem[5], vecs[i].e5);
         chk("mem6", mem[6], vecs[i].e6);
      end

      // st_done is a single-cycle pulse
      preload();
      do_store(32'h10, 2'd2, 32'hDEADBEEF, 0, 1'b0, lat);
      @(negedge cpu_clk);
      #1;
      chk("done_one_cycle", bus.st_done, 0);
      chk("busy_after_done", bus.busy, 0);

      // back-to-back: second store accepted in the st_done cycle
      preload();
      do_store(32'h10, 2'd2, 32'h01020304, 0, 1'b0, lat);
      chk("b2b_lat0", lat, 2);
      do_store(32'h14, 2'd0, 32'h00000099, 0, 1'b0, lat);
      chk("b2b_lat1", lat, 2);
      chk("b2b_mem4", mem[4], 32'h01020304);
      chk("b2b_mem5", mem[5], 32'h88776699);

      // wrap: half store at 0x1FF spans word 127 and word 0
      preload();
      do_store(32'h1FF, 2'd1, 32'h0000BEEF, 0, 1'b0, lat);
`ifdef MISALIGN_TRAP_EN
      chk("wrap_lat", lat, 0);
      chk("wrap_mem127", mem[127], 32'h0);
      chk("wrap_mem0", mem[0], 32'h0);
`else
      chk("wrap_lat", lat, 4);
      chk("wrap_mem127", mem[127], 32'hEF000000);
      chk("wrap_mem0", mem[0], 32'h000000BE);
`endif

`ifndef MISALIGN_TRAP_EN
      // reset while in RD1 of a spanning word store
      preload();
      bus.mem_grant = 1'b1;
      bus.st_addr   = 32'h13;
      bus.st_size   = 2'd2;
      bus.st_wdata  = 32'hAABBCCDD;
      bus.st_valid  = 1'b1;
      @(posedge cpu_clk);
      #1 bus.st_valid = 1'b0;
      repeat (2) @(negedge cpu_clk);
      @(negedge cpu_clk);
      #1;
      chk("rd1_raddr", bus.mem_raddr, 5);
      chk("rd1_busy", bus.busy, 1);
      cpu_rst = 1'b1;
      @(negedge cpu_clk);
      #1;
      chk_reset_outputs("midrst");
      cpu_rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge cpu_clk);
         #1;
         if (bus.st_done) seen = 1'b1;
      end
      chk("midrst_no_done", seen, 0);
      chk("midrst_mem4", mem[4], 32'hDD332211);
      chk("midrst_mem5", mem[5], 32'h88776655);
`endif

      // random stores with random grant against the reference model
      preload();
      for (int i = 0; i < 60; i++) begin
         a = $urandom_range(0, 511);
         s = 2'($urandom_range(0, 3));
         d = $urandom;
         n = size_bytes(s);
         off = int'(a[1:0]);
         minlat = (s == 2'd3) ? 0 : (off + n > 4) ? 4 : 2;
`ifdef MISALIGN_TRAP_EN
         if (off + n > 4) minlat = 0;
`endif
         do_store(a, s, d, 0, 1'b1, lat);
         chk("rand_lat_min", (lat >= minlat) ? 1 : 0, 1);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(negedge cpu_clk);
            #1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
